// File: rtl/i2c_slave_memory_if.sv
// i2c_slave_memory_if: I2C bus pins shared by a master and the memory target
//   scl    : bus clock
//   sda_in : resolved SDA line level (wired-AND of all drivers)
//   sda_oe : target pull-down enable, 1 drives SDA low
interface i2c_slave_memory_if;
   logic scl;
   logic sda_in;
   logic sda_oe;
   modport master (output scl, output sda_in, input sda_oe);
   modport slave (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_slave_memory.sv
// i2c_slave_memory: I2C target with a 64x8 register file and auto-increment pointer
//   clk8x    : system clock, at least 8x SCL
//   reset    : asynchronous active-high reset
//   bus      : scl / sda_in in, sda_oe out (open-drain pull-down)
//   busy     : transfer to this device in progress
//   wr_pulse : one-cycle strobe per committed write
//   wr_addr  : address of the last committed write
//   wr_data  : data of the last committed write
module i2c_slave_memory #(
   parameter logic [6:0] DEV_ADDR = 7'h01
) (
   input  logic              clk8x,
   input  logic              reset,
   i2c_slave_memory_if.slave bus,
   output logic              busy,
   output logic              wr_pulse,
   output logic [5:0]        wr_addr,
   output logic [7:0]        wr_data
);
   typedef enum logic [3:0] {
      ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_MEM_ADDR, ST_MEM_ACK,
      ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
   } state_t;
   state_t      state_q, state_d;
   logic [2:0]  scl_sync_q, scl_sync_d;
   logic [2:0]  sda_sync_q, sda_sync_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  sh_q, sh_d;
   logic        rw_q, rw_d;
   logic [5:0]  ptr_q, ptr_d;
   logic        sda_oe_q, sda_oe_d;
   logic        busy_q, busy_d;
   logic        wr_pulse_q, wr_pulse_d;
   logic [5:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic [7:0]  mem_q [64];
   logic [7:0]  mem_d [64];
   logic        scl_hi, scl_p, sda, sda_p, rise, fall, start, stop;
   logic [7:0]  shin;
   logic [5:0]  ptr_inc;
   // [1] is the synchronised level, [2] the previous sample for edge detection
   assign scl_hi  = scl_sync_q[1];
   assign scl_p   = scl_sync_q[2];
   assign sda     = sda_sync_q[1];
   assign sda_p   = sda_sync_q[2];
   assign rise    = scl_hi & ~scl_p;
   assign fall    = ~scl_hi & scl_p;
   assign start   = scl_hi & scl_p & sda_p & ~sda;
   assign stop    = scl_hi & scl_p & ~sda_p & sda;
   assign shin    = {sh_q[6:0], sda};
   assign ptr_inc = ptr_q + 6'd1;
   always_comb begin
      scl_sync_d = {scl_sync_q[1:0], bus.scl};
      sda_sync_d = {sda_sync_q[1:0], bus.sda_in};
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      rw_d       = rw_q;
      ptr_d      = ptr_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      wr_pulse_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      mem_d      = mem_q;
      if (start) begin
         state_d  = ST_DEV_ADDR;
         cnt_d    = '0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b1;
      end else if (stop) begin
         state_d  = ST_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_DEV_ADDR:
               if (rise) begin
                  sh_d  = shin;
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     rw_d    = shin[0];
                     state_d = (shin[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_IGNORE;
                     busy_d  = shin[7:1] == DEV_ADDR;
                  end
               end
            // sda_oe doubles as the ACK phase flag: the first fall starts the
            // pull-down, the second fall ends the ACK bit
            ST_DEV_ACK, ST_MEM_ACK, ST_WR_ACK:
               if (fall) begin
                  sda_oe_d = ~sda_oe_q;
                  if (sda_oe_q) begin
                     cnt_d   = '0;
                     sh_d    = mem_q[ptr_q];
                     state_d = (state_q == ST_DEV_ACK) ? ST_MEM_ADDR :
                               (state_q == ST_MEM_ACK && rw_q) ? ST_RD_DATA : ST_WR_DATA;
                     if (state_q == ST_MEM_ACK && rw_q) sda_oe_d = ~mem_q[ptr_q][7];
                  end
               end
            ST_MEM_ADDR:
               if (rise) begin
                  sh_d  = shin;
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     ptr_d   = shin[5:0];
                     state_d = ST_MEM_ACK;
                  end
               end
            ST_WR_DATA:
               if (rise) begin
                  sh_d  = shin;
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     mem_d[ptr_q] = shin;
                     wr_pulse_d   = 1'b1;
                     wr_addr_d    = ptr_q;
                     wr_data_d    = shin;
                     ptr_d        = ptr_inc;
                     state_d      = ST_WR_ACK;
                  end
               end
            // sh_q[7] always holds the bit to present on the next fall
            ST_RD_DATA: begin
               if (fall) sda_oe_d = ~sh_q[7];
               if (rise) begin
                  sh_d  = {sh_q[6:0], 1'b0};
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) state_d = ST_RD_ACK;
               end
            end
            ST_RD_ACK: begin
               if (fall) sda_oe_d = 1'b0;
               if (rise) begin
                  if (sda) state_d = ST_IGNORE;
                  else begin
                     ptr_d   = ptr_inc;
                     sh_d    = mem_q[ptr_inc];
                     cnt_d   = '0;
                     state_d = ST_RD_DATA;
                  end
               end
            end
            ST_IGNORE: sda_oe_d = 1'b0;
            default: begin
               state_d  = ST_IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end
   always_ff @(posedge clk8x or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         cnt_q      <= '0;
         sh_q       <= '0;
         rw_q       <= 1'b0;
         ptr_q      <= '0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         wr_pulse_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         mem_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         rw_q       <= rw_d;
         ptr_q      <= ptr_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         wr_pulse_q <= wr_pulse_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         mem_q      <= mem_d;
      end
   end
   assign bus.sda_oe = sda_oe_q;
   assign busy       = busy_q;
   assign wr_pulse   = wr_pulse_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
endmodule

// File: tb/tb_i2c_slave_memory.sv
// tb_i2c_slave_memory: bit-banged I2C master against a byte-level memory model
module tb_i2c_slave_memory;
   localparam int Q = 50;
   typedef struct {
      logic [7:0] dev;
      logic [7:0] maddr;
      logic [7:0] data;
      logic       ack;
   } vec_t;
   logic       clk8x = 1'b0;
   logic       reset = 1'b1;
   logic       m_sda = 1'b1;
   logic       busy, wr_pulse;
   logic [5:0] wr_addr;
   logic [7:0] wr_data;
   int         checks = 0;
   int         errors = 0;
   int         wr_cnt = 0;
   logic [5:0] last_wa;
   logic [7:0] last_wd;
   logic [7:0] mem_m [64];
   logic [5:0] ptr_m;
   logic [7:0] wbuf [16];
   vec_t       vt [8];
   i2c_slave_memory_if bus ();
   i2c_slave_memory #(.DEV_ADDR(7'h01)) dut (
      .clk8x(clk8x),
      .reset(reset),
      .bus(bus),
      .busy(busy),
      .wr_pulse(wr_pulse),
      .wr_addr(wr_addr),
      .wr_data(wr_data)
   );
   assign bus.sda_in = m_sda & ~bus.sda_oe;
   always #5 clk8x = ~clk8x;
   always @(negedge clk8x) if (wr_pulse) begin
      wr_cnt++;
      last_wa = wr_addr;
      last_wd = wr_data;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic clk_bit(input logic b, output logic oe);
      #Q m_sda = b;
      #Q bus.scl = 1'b1;
      #Q oe = bus.sda_oe;
      #Q bus.scl = 1'b0;
   endtask
   task automatic i2c_start();
      m_sda = 1'b1;
      #Q bus.scl = 1'b1;
      #Q m_sda = 1'b0;
      #Q bus.scl = 1'b0;
   endtask
   task automatic i2c_stop();
      #Q m_sda = 1'b0;
      #Q bus.scl = 1'b1;
      #Q m_sda = 1'b1;
      #Q;
   endtask
   task automatic send_byte(input logic [7:0] b);
      logic oe;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], oe);
   endtask
   task automatic get_ack(output logic a);
      clk_bit(1'b1, a);
   endtask
   task automatic read_byte(output logic [7:0] v, input logic ack);
      logic oe;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, oe);
         v[i] = ~oe;
      end
      clk_bit(~ack, oe);
      chk("rd master ack released", oe, 0);
   endtask
   task automatic wr_xfer(input logic [7:0] ma, input int n);
      logic a;
      int p;
      logic [5:0] ea;
      p = wr_cnt;
      ea = '0;
      i2c_start();
      send_byte(8'h02);
      get_ack(a);
      chk("wr dev ack", a, 1);
      send_byte(ma);
      get_ack(a);
      chk("wr mem ack", a, 1);
      ptr_m = ma[5:0];
      for (int k = 0; k < n; k++) begin
         send_byte(wbuf[k]);
         get_ack(a);
         chk("wr data ack", a, 1);
         mem_m[ptr_m] = wbuf[k];
         ea = ptr_m;
         ptr_m++;
      end
      i2c_stop();
      chk("wr pulses", wr_cnt - p, n);
      chk("wr addr", last_wa, ea);
      chk("wr data", last_wd, wbuf[n-1]);
      chk("wr busy after stop", busy, 0);
   endtask
   task automatic rd_xfer(input logic [7:0] ma, input int n);
      logic a;
      logic [7:0] v;
      i2c_start();
      send_byte(8'h03);
      get_ack(a);
      chk("rd dev ack", a, 1);
      send_byte(ma);
      get_ack(a);
      chk("rd mem ack", a, 1);
      ptr_m = ma[5:0];
      for (int k = 0; k < n; k++) begin
         read_byte(v, k != n - 1);
         chk("rd data", v, mem_m[ptr_m]);
         ptr_m++;
      end
      i2c_stop();
      chk("rd busy after stop", busy, 0);
      chk("rd oe after stop", bus.sda_oe, 0);
   endtask
   initial begin
      logic a, oe, exp_oe;
      logic [7:0] v, ma;
      int p, n;
      bus.scl = 1'b1;
      foreach (mem_m[i]) mem_m[i] = '0;
      vt[0] = '{8'h02, 8'h01, 8'h5F, 1'b1};
      vt[1] = '{8'h03, 8'h01, 8'h5F, 1'b1};
      vt[2] = '{8'h04, 8'h01, 8'h00, 1'b0};
      vt[3] = '{8'h03, 8'hC1, 8'h5F, 1'b1};
      vt[4] = '{8'h82, 8'h00, 8'h00, 1'b0};
      vt[5] = '{8'h02, 8'hA0, 8'h3C, 1'b1};
      vt[6] = '{8'h03, 8'h20, 8'h3C, 1'b1};
      vt[7] = '{8'h00, 8'h00, 8'h00, 1'b0};
      #33 reset = 1'b0;
      #Q;
      chk("reset oe", bus.sda_oe, 0);
      chk("reset busy", busy, 0);
      chk("reset wr_pulse", wr_pulse, 0);
      chk("reset wr_addr", wr_addr, 0);
      chk("reset wr_data", wr_data, 0);
      foreach (vt[i]) begin
         i2c_start();
         send_byte(vt[i].dev);
         get_ack(a);
         chk("tbl dev ack", a, vt[i].ack);
         chk("tbl busy", busy, vt[i].ack);
         if (vt[i].ack) begin
            send_byte(vt[i].maddr);
            get_ack(a);
            chk("tbl mem ack", a, 1);
            ptr_m = vt[i].maddr[5:0];
            if (vt[i].dev[0]) begin
               read_byte(v, 1'b0);
               chk("tbl rd data", v, vt[i].data);
            end else begin
               p = wr_cnt;
               send_byte(vt[i].data);
               get_ack(a);
               chk("tbl wr ack", a, 1);
               mem_m[ptr_m] = vt[i].data;
               chk("tbl wr pulses", wr_cnt - p, 1);
               chk("tbl wr addr", last_wa, vt[i].maddr[5:0]);
               chk("tbl wr data", last_wd, vt[i].data);
            end
         end
         i2c_stop();
         chk("tbl busy after stop", busy, 0);
         chk("tbl oe after stop", bus.sda_oe, 0);
      end
      wbuf[0] = 8'hAA;
      wbuf[1] = 8'hBB;
      wr_xfer(8'h3F, 2);
      rd_xfer(8'h3F, 2);
      rd_xfer(8'h00, 1);
      p = wr_cnt;
      i2c_start();
      send_byte(8'h02);
      get_ack(a);
      send_byte(8'h10);
      get_ack(a);
      chk("abort mem ack", a, 1);
      for (int i = 0; i < 4; i++) clk_bit(i[0], oe);
      i2c_stop();
      chk("abort stop no pulse", wr_cnt - p, 0);
      chk("abort stop oe", bus.sda_oe, 0);
      chk("abort stop busy", busy, 0);
      p = wr_cnt;
      i2c_start();
      send_byte(8'h02);
      get_ack(a);
      send_byte(8'h11);
      get_ack(a);
      for (int i = 0; i < 3; i++) clk_bit(1'b1, oe);
      chk("abort start no pulse", wr_cnt - p, 0);
      wbuf[0] = 8'h77;
      wr_xfer(8'h10, 1);
      rd_xfer(8'h10, 2);
      for (int r = 0; r < 16; r++) begin
         n = $urandom_range(1, 4);
         ma = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
            wr_xfer(ma, n);
         end else rd_xfer(ma, n);
      end
      wbuf[0] = 8'h0F;
      wr_xfer(8'h05, 1);
      i2c_start();
      send_byte(8'h03);
      get_ack(a);
      send_byte(8'h05);
      get_ack(a);
      clk_bit(1'b1, oe);
      clk_bit(1'b1, oe);
      #Q;
      exp_oe = ~mem_m[5][5];
      chk("rd drive before reset", bus.sda_oe, exp_oe);
      @(negedge clk8x);
      #1 reset = 1'b1;
      #2;
      chk("async reset oe", bus.sda_oe, 0);
      chk("async reset busy", busy, 0);
      chk("async reset wr_data", wr_data, 0);
      #5 reset = 1'b0;
      foreach (mem_m[i]) mem_m[i] = '0;
      rd_xfer(8'h05, 2);
      rd_xfer(8'h3F, 2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_slave_memory.md
# i2c_slave_memory

I2C target (slave) that answers the transfers issued by `I2C_Master`: it recognises its 7-bit device address, takes a one-byte memory address, then writes or reads bytes of an internal 64x8 register file with address auto-increment. It sits on the far side of the I2C bus from `I2C_Master`, oversamples SCL/SDA on the system clock and drives SDA open-drain. It is the bus-level responder for APB-initiated I2C accesses.

## Interface
- `DEV_ADDR`, default 7'h01: 7-bit device address this target answers to.
- `clk8x`  in  1: system clock; must be at least 8x the SCL frequency.
- `reset`  in  1: asynchronous, active-high reset.
- `scl`  in  1: I2C clock from the bus. Asynchronous to `clk8x`.
- `sda_in`  in  1: resolved SDA line level. Asynchronous to `clk8x`.
- `sda_oe`  out  1: 1 pulls SDA low; 0 releases the line (open-drain).
- `busy`  out  1: high from a START addressed to this device until STOP, a START, or address mismatch.
- `wr_pulse`  out  1: one-cycle strobe on each committed memory write.
- `wr_addr`  out  6: address of the last committed write.
- `wr_data`  out  8: data of the last committed write.

## Operation
- SCL and SDA each pass through a 2-flop synchroniser. Rise and fall of SCL are detected from the synchronised samples.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
  - Either event is honoured in every state.
  - START always goes to DEV_ADDR with the bit counter cleared.
  - STOP always goes to IDLE.
- Bits are sampled on the SCL rise. `sda_oe` changes only on the SCL fall.
- Byte order on the wire: device address (7 bits, MSB first) + R/W (1 = read), ACK, memory address byte, ACK, then data bytes.
  - Only bits [5:0] of the memory address byte are used; bits [7:6] are ignored.
  - The memory address byte is sent for reads as well as writes. There is no repeated START.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits.
    - If the top 7 bits equal `DEV_ADDR`, latch R/W and go to DEV_ACK.
    - Otherwise go to IGNORE.
  - DEV_ACK: drive `sda_oe`=1 for one SCL bit, then go to MEM_ADDR.
  - MEM_ADDR: shift 8 bits, load the pointer with bits [5:0], then go to MEM_ACK.
  - MEM_ACK: drive `sda_oe`=1 for one bit.
    - Then go to WR_DATA if R/W=0.
    - If R/W=1, load the shift register with mem[pointer] and go to RD_DATA.
  - WR_DATA: shift 8 bits.
    - On the 8th SCL rise: write the memory, pulse `wr_pulse`, update `wr_addr`/`wr_data`, increment the pointer, go to WR_ACK.
  - WR_ACK: drive `sda_oe`=1 for one bit, then go to WR_DATA.
  - RD_DATA: for each bit, drive `sda_oe` = ~bit (MSB first). After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's ACK on the SCL rise.
    - 0 (ACK): increment the pointer, reload the shift register, go to RD_DATA.
    - 1 (NACK): go to IGNORE.
  - IGNORE: `sda_oe`=0; wait for STOP or START.
- The pointer wraps from 6'h3F to 6'h00.
- Memory resets to all zeros.

## Timing
- Reset values: `sda_oe`=0, `busy`=0, `wr_pulse`=0, `wr_addr`=0, `wr_data`=0, state IDLE, memory all zero.
- Input latency: 2 cycles of synchronisation plus 1 cycle of edge detection.
- `sda_oe` update latency: `sda_oe` updates within 3 `clk8x` cycles of the bus SCL fall, well inside the SCL-low half-period at the minimum 8x ratio.
- ACK drive window: `sda_oe` is asserted from the SCL fall that ends bit 8 until the SCL fall that ends the ACK bit.
- Write latency: `wr_pulse` is high exactly one cycle, in the cycle after the detected 8th data SCL rise. The memory write is visible to a read in the next byte.
- A START or STOP arriving mid-byte aborts the byte.
  - No memory write occurs.
  - `sda_oe` is released in the same cycle the event is detected.
- `reset` asserted mid-transfer forces all reset values immediately, independent of `clk8x`.
- SDA changes while SCL is low are ignored as data.

## Test plan
- Write: START, 0x02 (device 0x01, write), ACK, 0x01, ACK, 0x5F, STOP.
  - Required: `sda_oe` low-drives on the 3 ACK bits.
  - Required: `wr_pulse` once, with `wr_addr`=0x01 and `wr_data`=0x5F.
  - Required: mem[1]=0x5F.
- Read back: START, 0x03, ACK, 0x01, ACK.
  - Required: the slave shifts out 0x5F (`sda_oe` = 1,0,1,0,0,0,0,0).
  - Then: master NACK, STOP; state returns to IDLE with `busy`=0.
- Address mismatch: START, 0x04.
  - Required: no ACK (`sda_oe` stays 0) and `busy` drops.
  - Required: a following STOP leaves the state in IDLE.
- Burst with wrap: write to memory address 0x3F with data 0xAA then 0xBB.
  - Required: mem[0x3F]=0xAA and mem[0x00]=0xBB.
  - Required: `wr_pulse` twice.
- Abort: STOP after 4 bits of a data byte.
  - Required: no `wr_pulse` and `sda_oe`=0.
  - Required: the next START+0x02 is ACKed normally.
- Async reset asserted during RD_DATA.
  - Required: `sda_oe`=0 and the state returns to IDLE without a `clk8x` edge.
  - Required: memory reads 0x00 afterwards.
